// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter.
// The prescale signal exists only when COUNTER_PRESCALE_EN is defined.
interface param_updown_counter_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  enable;
    logic                  load;
    logic                  up_dn;
    logic [WIDTH-1:0]      data;
`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale;
`endif
    logic [WIDTH-1:0]      count;
    logic                  tc;
    logic                  at_max;
    logic                  at_min;

`ifdef COUNTER_PRESCALE_EN
    modport master (
        output enable, load, up_dn, data, prescale,
        input  count, tc, at_max, at_min
    );
    modport slave (
        input  enable, load, up_dn, data, prescale,
        output count, tc, at_max, at_min
    );
`else
    modport master (
        output enable, load, up_dn, data,
        input  count, tc, at_max, at_min
    );
    modport slave (
        input  enable, load, up_dn, data,
        output count, tc, at_max, at_min
    );
`endif
endinterface

// File: rtl/param_updown_counter.sv
// Modulo-N up/down counter with wrap or saturate mode, load clamp and terminal-count pulse.
// Optional step prescaler compiled in with COUNTER_PRESCALE_EN.
module param_updown_counter #(
    parameter int WIDTH      = 8,
    parameter int MODULO     = 256,
    parameter bit SATURATE   = 1'b0,
    parameter int PRESCALE_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    param_updown_counter_if.slave      bus
);
    if (WIDTH < 2 || MODULO < 2 || 64'(MODULO) > (64'd1 << WIDTH)) begin : g_bad_params
        $error("param_updown_counter: illegal WIDTH/MODULO combination");
    end

    localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MODULO - 1);
    localparam logic [WIDTH:0]   MODULO_EXT = (WIDTH+1)'(MODULO);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_step;
    logic [WIDTH-1:0] w_load_val;

    // Out-of-range load data clamps to the top of the range.
    assign w_load_val = ({1'b0, bus.data} < MODULO_EXT) ? bus.data : MAX_VAL;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] r_prescaler;
    logic                  w_ps_hit;

    assign w_ps_hit = (r_prescaler == bus.prescale);
    assign w_step   = bus.enable && !bus.load && w_ps_hit;

    always_ff @(posedge clk) begin
        if (reset || bus.load) begin
            r_prescaler <= '0;
        end else if (bus.enable) begin
            r_prescaler <= w_ps_hit ? '0 : r_prescaler + 1'b1;
        end
    end
`else
    assign w_step = bus.enable && !bus.load;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.load) begin
                r_count <= w_load_val;
            end else if (w_step) begin
                if (bus.up_dn) begin
                    if (r_count == MAX_VAL) begin
                        r_tc <= 1'b1;
                        if (!SATURATE) begin
                            r_count <= '0;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end else begin
                    if (r_count == '0) begin
                        r_tc <= 1'b1;
                        if (!SATURATE) begin
                            r_count <= MAX_VAL;
                        end
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
            end
        end
    end

    assign bus.count  = r_count;
    assign bus.tc     = r_tc;
    assign bus.at_max = (r_count == MAX_VAL);
    assign bus.at_min = (r_count == '0);
endmodule

// File: tb/tb_param_updown_counter.sv
// Drives a wrap-mode and a saturate-mode counter (MODULO=10) with directed and random stimulus
// and compares both against an arithmetic reference model every cycle.
module tb_param_updown_counter;
    localparam int WIDTH  = 8;
    localparam int MODULO = 10;
    localparam int PS_W   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    param_updown_counter_if #(.WIDTH(WIDTH), .PRESCALE_W(PS_W)) if_w ();
    param_updown_counter_if #(.WIDTH(WIDTH), .PRESCALE_W(PS_W)) if_s ();

    param_updown_counter #(.WIDTH(WIDTH), .MODULO(MODULO), .SATURATE(1'b0), .PRESCALE_W(PS_W))
        u_wrap (.clk(clk), .reset(reset), .bus(if_w));
    param_updown_counter #(.WIDTH(WIDTH), .MODULO(MODULO), .SATURATE(1'b1), .PRESCALE_W(PS_W))
        u_sat  (.clk(clk), .reset(reset), .bus(if_s));

    int checks = 0;
    int errors = 0;

    int m_cnt [2];
    int m_tc  [2];
    int m_ps  = 0;
    int ps_val = 0;

    task automatic check_value(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour: priority reset > load > step, arithmetic kept in 0..MODULO-1.
    task automatic model_update(input bit rst, input bit ld, input bit en, input bit up, input int d);
        bit do_step;
        do_step = en && !ld;
        if (rst) begin
            m_ps = 0;
        end else if (ld) begin
            m_ps = 0;
        end else if (en) begin
`ifdef COUNTER_PRESCALE_EN
            if (m_ps == ps_val) begin
                m_ps = 0;
            end else begin
                m_ps = (m_ps + 1) % (1 << PS_W);
                do_step = 1'b0;
            end
`endif
        end
        for (int k = 0; k < 2; k++) begin
            m_tc[k] = 0;
            if (rst) begin
                m_cnt[k] = 0;
            end else if (ld) begin
                m_cnt[k] = (d < MODULO) ? d : MODULO - 1;
            end else if (do_step) begin
                if (up) begin
                    if (m_cnt[k] == MODULO - 1) begin
                        m_tc[k] = 1;
                        if (k == 0) m_cnt[k] = 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else begin
                    if (m_cnt[k] == 0) begin
                        m_tc[k] = 1;
                        if (k == 0) m_cnt[k] = MODULO - 1;
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check_value("wrap.count",  int'(if_w.count),  m_cnt[0]);
        check_value("wrap.tc",     int'(if_w.tc),     m_tc[0]);
        check_value("wrap.at_max", int'(if_w.at_max), int'(m_cnt[0] == MODULO - 1));
        check_value("wrap.at_min", int'(if_w.at_min), int'(m_cnt[0] == 0));
        check_value("sat.count",   int'(if_s.count),  m_cnt[1]);
        check_value("sat.tc",      int'(if_s.tc),     m_tc[1]);
        check_value("sat.at_max",  int'(if_s.at_max), int'(m_cnt[1] == MODULO - 1));
        check_value("sat.at_min",  int'(if_s.at_min), int'(m_cnt[1] == 0));
    endtask

    task automatic step_cycle(input bit rst, input bit ld, input bit en, input bit up, input int d);
        @(negedge clk);
        reset      = rst;
        if_w.load  = ld;  if_s.load  = ld;
        if_w.enable = en; if_s.enable = en;
        if_w.up_dn = up;  if_s.up_dn = up;
        if_w.data  = WIDTH'(d); if_s.data = WIDTH'(d);
`ifdef COUNTER_PRESCALE_EN
        if_w.prescale = PS_W'(ps_val); if_s.prescale = PS_W'(ps_val);
`endif
        @(posedge clk);
        model_update(rst, ld, en, up, d);
        #1;
        $display("t=%0t rst=%0b ld=%0b en=%0b up=%0b d=%0d | wrap cnt=%0d tc=%0b | sat cnt=%0d tc=%0b",
                 $time, rst, ld, en, up, d, if_w.count, if_w.tc, if_s.count, if_s.tc);
        compare_all();
    endtask

    initial begin
        reset = 1'b1;
        if_w.enable = 1'b0; if_w.load = 1'b0; if_w.up_dn = 1'b1; if_w.data = '0;
        if_s.enable = 1'b0; if_s.load = 1'b0; if_s.up_dn = 1'b1; if_s.data = '0;
`ifdef COUNTER_PRESCALE_EN
        if_w.prescale = '0; if_s.prescale = '0;
`endif
        m_cnt[0] = 0; m_cnt[1] = 0; m_tc[0] = 0; m_tc[1] = 0;

        // Reset dominates load and enable.
        step_cycle(1, 1, 1, 1, 5);
        step_cycle(1, 1, 1, 1, 5);
        check_value("reset.count", int'(if_w.count), 0);
        check_value("reset.at_min", int'(if_w.at_min), 1);

        // Up through the range and wrap.
        for (int i = 0; i < 10; i++) step_cycle(0, 0, 1, 1, 0);
        check_value("wrap_up.count", int'(if_w.count), 0);
        check_value("wrap_up.tc", int'(if_w.tc), 1);

        // Down from zero wraps to the top, then steps normally.
        step_cycle(0, 0, 1, 0, 0);
        check_value("wrap_dn.count", int'(if_w.count), 9);
        check_value("wrap_dn.tc", int'(if_w.tc), 1);
        step_cycle(0, 0, 1, 0, 0);
        check_value("wrap_dn2.count", int'(if_w.count), 8);
        check_value("wrap_dn2.tc", int'(if_w.tc), 0);

        // Saturate at the top with tc held for back-to-back boundary steps.
        step_cycle(0, 1, 0, 1, 9);
        for (int i = 0; i < 3; i++) begin
            step_cycle(0, 0, 1, 1, 0);
            check_value("sat_hold.count", int'(if_s.count), 9);
            check_value("sat_hold.tc", int'(if_s.tc), 1);
        end

        // Load clamp, then load takes priority over enable.
        step_cycle(0, 1, 0, 1, 15);
        check_value("clamp.count", int'(if_w.count), 9);
        step_cycle(0, 1, 1, 0, 3);
        check_value("load_pri.count", int'(if_w.count), 3);
        check_value("load_pri.tc", int'(if_w.tc), 0);

`ifdef COUNTER_PRESCALE_EN
        // Prescaled stepping with an enable gap that must preserve phase.
        ps_val = 2;
        step_cycle(0, 1, 0, 1, 0);
        for (int i = 0; i < 4; i++) step_cycle(0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step_cycle(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step_cycle(0, 0, 1, 1, 0);
        check_value("prescale.count", int'(if_w.count), 3);
        ps_val = 0;
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit r_rst, r_ld, r_en, r_up;
            int r_d;
            r_rst = ($urandom_range(0, 49) == 0);
            r_ld  = ($urandom_range(0, 9) == 0);
            r_en  = ($urandom_range(0, 9) < 7);
            r_up  = $urandom_range(0, 1) == 1;
            r_d   = int'($urandom_range(0, 255));
`ifdef COUNTER_PRESCALE_EN
            if ($urandom_range(0, 29) == 0) ps_val = int'($urandom_range(0, 3));
`endif
            step_cycle(r_rst, r_ld, r_en, r_up, r_d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
